// File: rtl/hazard_ctrl_if.sv
// Hazard-controller bundle between the pipeline datapath and hazard_ctrl.
//   master : datapath side; drives the D-stage decode fields, PCSrcE and MemReadyM,
//            and receives the stall/flush/forward controls and the stall counter.
//   slave  : hazard_ctrl side; the mirror image.
// Signal names follow the datapath's stage-suffix naming (D/E/M/W).
interface hazard_ctrl_if #(
  parameter int unsigned XLEN_REGS = 32,
  parameter int unsigned CNT_W     = 16
);
  localparam int unsigned RegW = $clog2(XLEN_REGS);

  logic            ValidD;
  logic [RegW-1:0] Rs1D;
  logic [RegW-1:0] Rs2D;
  logic [RegW-1:0] RdD;
  logic            RegWE_D;
  logic            LoadD;
  logic            MemAccessD;
  logic            PCSrcE;
  logic            MemReadyM;

  logic             StallF;
  logic             StallD;
  logic             StallE;
  logic             StallM;
  logic             FlushD;
  logic             FlushE;
  logic             FlushW;
  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic [CNT_W-1:0] StallCount;

  modport master (
    output ValidD, Rs1D, Rs2D, RdD, RegWE_D, LoadD, MemAccessD, PCSrcE, MemReadyM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    input  ForwardAE, ForwardBE, StallCount
  );

  modport slave (
    input  ValidD, Rs1D, Rs2D, RdD, RegWE_D, LoadD, MemAccessD, PCSrcE, MemReadyM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    output ForwardAE, ForwardBE, StallCount
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the five-stage core (F, D, E, M, W).
// Shadows the register/memory fields of the instructions in E, M and W and
// drives stall, flush and operand-forward controls from them, plus a
// saturating count of cycles in which fetch was stalled.
// Ports:
//   clk   : single clock, rising edge.
//   reset : synchronous, active-high. Loads bubbles into every shadow stage.
//   hz    : hazard_ctrl_if slave modport (D-stage fields, PCSrcE, MemReadyM in;
//           Stall*/Flush*/Forward*E/StallCount out).
module hazard_ctrl #(
  parameter int unsigned XLEN_REGS = 32,
  parameter int unsigned CNT_W     = 16
) (
  input logic         clk,
  input logic         reset,
  hazard_ctrl_if.slave hz
);
  localparam int unsigned RegW = $clog2(XLEN_REGS);

  // Shadow state; a bubble is every field zero.
  logic [RegW-1:0] rs1_e_q, rs2_e_q, rd_e_q;
  logic            regwe_e_q, load_e_q, memacc_e_q;
  logic [RegW-1:0] rd_m_q;
  logic            regwe_m_q, memacc_m_q;
  logic [RegW-1:0] rd_w_q;
  logic            regwe_w_q;
  logic [CNT_W-1:0] stall_cnt_q;

  logic mem_wait, branch, load_use;
  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, flush_w;
  logic [1:0] fwd_a, fwd_b;

  assign mem_wait = memacc_m_q & ~hz.MemReadyM;
  assign branch   = hz.PCSrcE;
  assign load_use = hz.ValidD & load_e_q & regwe_e_q & (rd_e_q != '0) &
                    ((rd_e_q == hz.Rs1D) | (rd_e_q == hz.Rs2D));

  // Priority MemWait > Branch > LoadUse; a losing hazard is simply re-evaluated
  // next cycle from the held state, so nothing is lost.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    if (reset) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_w = 1'b1;
    end else if (mem_wait) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (branch) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (load_use) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  // M result beats W result; x0 is never forwarded.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (!reset) begin
      if (regwe_m_q && (rd_m_q != '0) && (rd_m_q == rs1_e_q)) begin
        fwd_a = 2'b10;
      end else if (regwe_w_q && (rd_w_q != '0) && (rd_w_q == rs1_e_q)) begin
        fwd_a = 2'b01;
      end
      if (regwe_m_q && (rd_m_q != '0) && (rd_m_q == rs2_e_q)) begin
        fwd_b = 2'b10;
      end else if (regwe_w_q && (rd_w_q != '0) && (rd_w_q == rs2_e_q)) begin
        fwd_b = 2'b01;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rs1_e_q     <= '0;
      rs2_e_q     <= '0;
      rd_e_q      <= '0;
      regwe_e_q   <= 1'b0;
      load_e_q    <= 1'b0;
      memacc_e_q  <= 1'b0;
      rd_m_q      <= '0;
      regwe_m_q   <= 1'b0;
      memacc_m_q  <= 1'b0;
      rd_w_q      <= '0;
      regwe_w_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      if (stall_f && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (mem_wait) begin
        // E and M hold; W drains as a bubble.
        rd_w_q    <= '0;
        regwe_w_q <= 1'b0;
      end else begin
        rd_w_q     <= rd_m_q;
        regwe_w_q  <= regwe_m_q;
        rd_m_q     <= rd_e_q;
        regwe_m_q  <= regwe_e_q;
        memacc_m_q <= memacc_e_q;
        if (branch || load_use || !hz.ValidD) begin
          rs1_e_q    <= '0;
          rs2_e_q    <= '0;
          rd_e_q     <= '0;
          regwe_e_q  <= 1'b0;
          load_e_q   <= 1'b0;
          memacc_e_q <= 1'b0;
        end else begin
          rs1_e_q    <= hz.Rs1D;
          rs2_e_q    <= hz.Rs2D;
          rd_e_q     <= hz.RdD;
          regwe_e_q  <= hz.RegWE_D;
          load_e_q   <= hz.LoadD;
          memacc_e_q <= hz.MemAccessD;
        end
      end
    end
  end

  assign hz.StallF     = stall_f;
  assign hz.StallD     = stall_d;
  assign hz.StallE     = stall_e;
  assign hz.StallM     = stall_m;
  assign hz.FlushD     = flush_d;
  assign hz.FlushE     = flush_e;
  assign hz.FlushW     = flush_w;
  assign hz.ForwardAE  = fwd_a;
  assign hz.ForwardBE  = fwd_b;
  assign hz.StallCount = stall_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (CNT_W = 4). Each scenario task drives a
// per-cycle stimulus table, pushes the expected outputs into a scoreboard queue
// and pops/compares once the combinational outputs have settled.
module tb_hazard_ctrl;
  localparam int unsigned CntW   = 4;
  localparam int unsigned CntMax = 15;

  typedef struct packed {
    logic       rst;
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       we;
    logic       ld;
    logic       mem;
    logic       pc;
    logic       rdy;
  } in_t;

  // Flag order: StallF StallD StallE StallM FlushD FlushE FlushW.
  typedef struct packed {
    logic [6:0]      flags;
    logic [1:0]      fa;
    logic [1:0]      fb;
    logic [CntW-1:0] cnt;
  } out_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  int   exp_cnt = 0;
  out_t sb[$];

  hazard_ctrl_if #(.XLEN_REGS(32), .CNT_W(CntW)) hz ();

  hazard_ctrl #(.XLEN_REGS(32), .CNT_W(CntW)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz.slave)
  );

  always #5 clk = ~clk;

  function automatic in_t mk_in(int valid, int rs1, int rs2, int rd, int we, int ld, int mem,
                                int pc = 0, int rdy = 1, int rst = 0);
    in_t r;
    r.rst = 1'(rst);
    r.valid = 1'(valid);
    r.rs1 = 5'(rs1);
    r.rs2 = 5'(rs2);
    r.rd = 5'(rd);
    r.we = 1'(we);
    r.ld = 1'(ld);
    r.mem = 1'(mem);
    r.pc = 1'(pc);
    r.rdy = 1'(rdy);
    return r;
  endfunction

  function automatic out_t mk_out(logic [6:0] flags, logic [1:0] fa, logic [1:0] fb);
    out_t r;
    r.flags = flags;
    r.fa = fa;
    r.fb = fb;
    r.cnt = '0;
    return r;
  endfunction

  task automatic drive(input in_t s);
    reset = s.rst;
    hz.ValidD = s.valid;
    hz.Rs1D = s.rs1;
    hz.Rs2D = s.rs2;
    hz.RdD = s.rd;
    hz.RegWE_D = s.we;
    hz.LoadD = s.ld;
    hz.MemAccessD = s.mem;
    hz.PCSrcE = s.pc;
    hz.MemReadyM = s.rdy;
  endtask

  // Pushes the expected outputs for this cycle, stamping the counter value the
  // DUT should show now and advancing the counter model across the next edge.
  task automatic push_exp(input out_t e, input logic rst);
    e.cnt = CntW'(exp_cnt);
    sb.push_back(e);
    if (rst) exp_cnt = 0;
    else if (e.flags[6] && exp_cnt < CntMax) exp_cnt++;
  endtask

  function automatic out_t sample();
    out_t r;
    r.flags = {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushD, hz.FlushE, hz.FlushW};
    r.fa = hz.ForwardAE;
    r.fb = hz.ForwardBE;
    r.cnt = hz.StallCount;
    return r;
  endfunction

  localparam logic [6:0] FNone  = 7'b0000000;
  localparam logic [6:0] FRst   = 7'b0000111;
  localparam logic [6:0] FLoad  = 7'b1100010;
  localparam logic [6:0] FBr    = 7'b0000110;
  localparam logic [6:0] FWait  = 7'b1111001;

  task automatic test_reset();
    in_t st[4];
    out_t ex[4];
    out_t got, want;
    st[0] = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    st[1] = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    st[2] = mk_in(0, 0, 0, 0, 0, 0, 0);
    st[3] = mk_in(0, 0, 0, 0, 0, 0, 0);
    ex[0] = mk_out(FRst, 2'b00, 2'b00);
    ex[1] = mk_out(FRst, 2'b00, 2'b00);
    ex[2] = mk_out(FNone, 2'b00, 2'b00);
    ex[3] = mk_out(FNone, 2'b00, 2'b00);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(st[i]);
      push_exp(ex[i], st[i].rst);
      #1;
      got = sample();
      want = sb.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL reset step %0d: got %h required %h", i, got, want);
      end
    end
  endtask

  // ADDI x1,x0,7 ; ADD x3,x1,x2 -> M-stage forward on A.
  task automatic test_back_to_back();
    in_t st[4];
    out_t ex[4];
    out_t got, want;
    st[0] = mk_in(1, 0, 0, 1, 1, 0, 0);
    st[1] = mk_in(1, 1, 2, 3, 1, 0, 0);
    st[2] = mk_in(0, 0, 0, 0, 0, 0, 0);
    st[3] = mk_in(0, 0, 0, 0, 0, 0, 0);
    ex[0] = mk_out(FNone, 2'b00, 2'b00);
    ex[1] = mk_out(FNone, 2'b00, 2'b00);
    ex[2] = mk_out(FNone, 2'b10, 2'b00);
    ex[3] = mk_out(FNone, 2'b00, 2'b00);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(st[i]);
      push_exp(ex[i], st[i].rst);
      #1;
      got = sample();
      want = sb.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL back_to_back step %0d: got %h required %h", i, got, want);
      end
    end
  endtask

  // ADDI x1 ; ADDI x4 (unrelated) ; ADD x3,x1,x2 -> W-stage forward on A.
  task automatic test_fwd_w();
    in_t st[5];
    out_t ex[5];
    out_t got, want;
    st[0] = mk_in(1, 0, 0, 1, 1, 0, 0);
    st[1] = mk_in(1, 0, 0, 4, 1, 0, 0);
    st[2] = mk_in(1, 1, 2, 3, 1, 0, 0);
    st[3] = mk_in(0, 0, 0, 0, 0, 0, 0);
    st[4] = mk_in(0, 0, 0, 0, 0, 0, 0);
    ex[0] = mk_out(FNone, 2'b00, 2'b00);
    ex[1] = mk_out(FNone, 2'b00, 2'b00);
    ex[2] = mk_out(FNone, 2'b00, 2'b00);
    ex[3] = mk_out(FNone, 2'b01, 2'b00);
    ex[4] = mk_out(FNone, 2'b00, 2'b00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(st[i]);
      push_exp(ex[i], st[i].rst);
      #1;
      got = sample();
      want = sb.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL fwd_w step %0d: got %h required %h", i, got, want);
      end
    end
  endtask

  // Producer writes x0: never forwarded from M or W.
  task automatic test_fwd_x0();
    in_t st[4];
    out_t ex[4];
    out_t got, want;
    st[0] = mk_in(1, 0, 0, 0, 1, 0, 0);
    st[1] = mk_in(1, 0, 0, 3, 1, 0, 0);
    st[2] = mk_in(0, 0, 0, 0, 0, 0, 0);
    st[3] = mk_in(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) ex[i] = mk_out(FNone, 2'b00, 2'b00);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(st[i]);
      push_exp(ex[i], st[i].rst);
      #1;
      got = sample();
      want = sb.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL fwd_x0 step %0d: got %h required %h", i, got, want);
      end
    end
  endtask

  // LW x5,0(x6) ; ADD x7,x1,x5 -> one stall, then W forward on B.
  task automatic test_load_use();
    in_t st[5];
    out_t ex[5];
    out_t got, want;
    st[0] = mk_in(1, 6, 0, 5, 1, 1, 1);
    st[1] = mk_in(1, 1, 5, 7, 1, 0, 0);
    st[2] = mk_in(1, 1, 5, 7, 1, 0, 0);
    st[3] = mk_in(0, 0, 0, 0, 0, 0, 0);
    st[4] = mk_in(0, 0, 0, 0, 0, 0, 0);
    ex[0] = mk_out(FNone, 2'b00, 2'b00);
    ex[1] = mk_out(FLoad, 2'b00, 2'b00);
    ex[2] = mk_out(FNone, 2'b00, 2'b00);
    ex[3] = mk_out(FNone, 2'b00, 2'b01);
    ex[4] = mk_out(FNone, 2'b00, 2'b00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(st[i]);
      push_exp(ex[i], st[i].rst);
      #1;
      got = sample();
      want = sb.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL load_use step %0d: got %h required %h", i, got, want);
      end
    end
  endtask

  task automatic test_branch();
    in_t st[4];
    out_t ex[4];
    out_t got, want;
    st[0] = mk_in(1, 1, 2, 3, 1, 0, 0, 1);
    st[1] = mk_in(1, 1, 2, 3, 1, 0, 0, 0);
    st[2] = mk_in(0, 0, 0, 0, 0, 0, 0);
    st[3] = mk_in(0, 0, 0, 0, 0, 0, 0);
    ex[0] = mk_out(FBr, 2'b00, 2'b00);
    ex[1] = mk_out(FNone, 2'b00, 2'b00);
    ex[2] = mk_out(FNone, 2'b00, 2'b00);
    ex[3] = mk_out(FNone, 2'b00, 2'b00);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(st[i]);
      push_exp(ex[i], st[i].rst);
      #1;
      got = sample();
      want = sb.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL branch step %0d: got %h required %h", i, got, want);
      end
    end
  endtask

  // SW reaches M, memory not ready for 3 cycles while a branch is pending.
  task automatic test_mem_wait();
    in_t st[7];
    out_t ex[7];
    out_t got, want;
    st[0] = mk_in(1, 6, 2, 0, 0, 0, 1);
    st[1] = mk_in(0, 0, 0, 0, 0, 0, 0);
    for (int i = 2; i < 5; i++) st[i] = mk_in(1, 1, 2, 3, 1, 0, 0, 1, 0);
    st[5] = mk_in(1, 1, 2, 3, 1, 0, 0, 1, 1);
    st[6] = mk_in(0, 0, 0, 0, 0, 0, 0);
    ex[0] = mk_out(FNone, 2'b00, 2'b00);
    ex[1] = mk_out(FNone, 2'b00, 2'b00);
    for (int i = 2; i < 5; i++) ex[i] = mk_out(FWait, 2'b00, 2'b00);
    ex[5] = mk_out(FBr, 2'b00, 2'b00);
    ex[6] = mk_out(FNone, 2'b00, 2'b00);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive(st[i]);
      push_exp(ex[i], st[i].rst);
      #1;
      got = sample();
      want = sb.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL mem_wait step %0d: got %h required %h", i, got, want);
      end
    end
  endtask

  // Reset in the middle of a memory wait: clears the wait and the counter.
  task automatic test_reset_mid();
    in_t st[6];
    out_t ex[6];
    out_t got, want;
    st[0] = mk_in(1, 6, 2, 0, 0, 0, 1);
    st[1] = mk_in(0, 0, 0, 0, 0, 0, 0);
    st[2] = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    st[3] = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    st[4] = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    st[5] = mk_in(0, 0, 0, 0, 0, 0, 0);
    ex[0] = mk_out(FNone, 2'b00, 2'b00);
    ex[1] = mk_out(FNone, 2'b00, 2'b00);
    ex[2] = mk_out(FWait, 2'b00, 2'b00);
    ex[3] = mk_out(FRst, 2'b00, 2'b00);
    ex[4] = mk_out(FNone, 2'b00, 2'b00);
    ex[5] = mk_out(FNone, 2'b00, 2'b00);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(st[i]);
      push_exp(ex[i], st[i].rst);
      #1;
      got = sample();
      want = sb.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL reset_mid step %0d: got %h required %h", i, got, want);
      end
    end
  endtask

  // 20 consecutive wait cycles: the 4-bit counter must stop at 15.
  task automatic test_saturation();
    in_t st;
    out_t ex;
    out_t got, want;
    for (int i = 0; i < 23; i++) begin
      if (i == 0) begin
        st = mk_in(1, 6, 2, 0, 0, 0, 1);
        ex = mk_out(FNone, 2'b00, 2'b00);
      end else if (i == 1) begin
        st = mk_in(0, 0, 0, 0, 0, 0, 0);
        ex = mk_out(FNone, 2'b00, 2'b00);
      end else if (i < 22) begin
        st = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        ex = mk_out(FWait, 2'b00, 2'b00);
      end else begin
        st = mk_in(0, 0, 0, 0, 0, 0, 0);
        ex = mk_out(FNone, 2'b00, 2'b00);
      end
      @(negedge clk);
      drive(st);
      push_exp(ex, st.rst);
      #1;
      got = sample();
      want = sb.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL saturation step %0d: got %h required %h", i, got, want);
      end
    end
  endtask

  initial begin
    drive(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    test_reset();
    test_back_to_back();
    test_fwd_w();
    test_fwd_x0();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_reset_mid();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
